// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR datapath constants and the serializer buffer occupancy type.
package fir_pkg;

  localparam int LANES     = 6;
  localparam int FIR_IN_W  = 16;
  localparam int FIR_ACC_W = 32;
  localparam int OUT_W     = 16;
  localparam int SHIFT     = 15;
  localparam int DEPTH     = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

endpackage

// File: rtl/fir_out_serializer_if.sv
// rtl/fir_out_serializer_if.sv - block-in / sample-out stream bundle of the FIR output serializer.
interface fir_out_serializer_if #(
  parameter int LANES = fir_pkg::LANES,
  parameter int IN_W  = fir_pkg::FIR_ACC_W,
  parameter int OUT_W = fir_pkg::OUT_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*IN_W-1:0] din;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      dout;
  logic                  dout_sat;
  logic                  dout_last;

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, dout_sat, dout_last
  );

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, dout_sat, dout_last
  );

endinterface

// File: rtl/fir_requant.sv
// rtl/fir_requant.sv - one-lane requantizer: arithmetic shift then saturate to OUT_W.
// FIR_OUT_SER_ROUND_EN selects round-half-up; otherwise truncation toward -inf.
module fir_requant #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic [IN_W-1:0]  i_x,
  output logic [OUT_W-1:0] o_y,
  output logic             o_sat
);

  localparam logic signed [IN_W:0] C_MAX = (IN_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IN_W:0] C_MIN = ~C_MAX;

  logic signed [IN_W:0] w_ext;
  logic signed [IN_W:0] w_s;
  logic signed [IN_W:0] w_y;

  // One guard bit so the rounding add cannot wrap near full scale.
  assign w_ext = {i_x[IN_W-1], i_x};

`ifdef FIR_OUT_SER_ROUND_EN
  localparam logic signed [IN_W:0] C_RND = (IN_W+1)'(64'sd1 <<< (SHIFT - 1));
  assign w_s = w_ext + C_RND;
`else
  assign w_s = w_ext;
`endif

  assign w_y = w_s >>> SHIFT;

  always_comb begin
    o_y   = w_y[OUT_W-1:0];
    o_sat = 1'b0;
    if (w_y > C_MAX) begin
      o_y   = C_MAX[OUT_W-1:0];
      o_sat = 1'b1;
    end else if (w_y < C_MIN) begin
      o_y   = C_MIN[OUT_W-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/fir_out_serializer.sv
// rtl/fir_out_serializer.sv - requantizes 6-lane FIR blocks, buffers DEPTH blocks, emits one sample per cycle.
// Rounding mode is chosen in fir_requant by FIR_OUT_SER_ROUND_EN.
module fir_out_serializer #(
  parameter int LANES = fir_pkg::LANES,
  parameter int IN_W  = fir_pkg::FIR_ACC_W,
  parameter int OUT_W = fir_pkg::OUT_W,
  parameter int SHIFT = fir_pkg::SHIFT,
  parameter int DEPTH = fir_pkg::DEPTH
) (
  input logic                 clk,
  input logic                 rst_n,
  fir_out_serializer_if.slave s_if
);

  import fir_pkg::*;

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(DEPTH);
  localparam logic [LANE_W-1:0] C_LAST = LANE_W'(LANES - 1);

  logic [OUT_W-1:0]  r_data [DEPTH][LANES];
  logic              r_sat  [DEPTH][LANES];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [LANE_W-1:0] r_lane;

  logic [OUT_W-1:0]  w_q_y   [LANES];
  logic              w_q_sat [LANES];
  occ_e              w_occ;
  logic              w_push;
  logic              w_pop;
  logic              w_pop_last;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fir_requant #(
      .IN_W (IN_W),
      .OUT_W(OUT_W),
      .SHIFT(SHIFT)
    ) u_requant (
      .i_x  (s_if.din[g*IN_W +: IN_W]),
      .o_y  (w_q_y[g]),
      .o_sat(w_q_sat[g])
    );
  end

  always_comb begin
    w_occ = OCC_PARTIAL;
    if (r_count == '0) begin
      w_occ = OCC_EMPTY;
    end else if (r_count == C_FULL) begin
      w_occ = OCC_FULL;
    end
  end

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a full buffer.
  assign s_if.in_ready  = rst_n & (w_occ != OCC_FULL);
  assign s_if.out_valid = (w_occ != OCC_EMPTY);

  assign w_push     = s_if.in_valid & s_if.in_ready;
  assign w_pop      = s_if.out_valid & s_if.out_ready;
  assign w_pop_last = w_pop & (r_lane == C_LAST);

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int k = 0; k < LANES; k++) begin
        r_data[r_wr_ptr][k] <= w_q_y[k];
        r_sat[r_wr_ptr][k]  <= w_q_sat[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_lane   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_lane <= w_pop_last ? '0 : r_lane + 1'b1;
      end
      if (w_pop_last) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop_last})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign s_if.dout      = r_data[r_rd_ptr][r_lane];
  assign s_if.dout_sat  = r_sat[r_rd_ptr][r_lane];
  assign s_if.dout_last = (r_lane == C_LAST);

endmodule

// File: doc/fir_out_serializer.md
# fir_out_serializer

Downstream stage of the 6-lane parallel FIR. Accepts one block of six 32-bit filter outputs per handshake, requantizes each lane to 16 bits (shift, optional rounding, saturation) and buffers up to DEPTH blocks. Emits the samples one per cycle, lane 0 first, on a valid/ready stream toward the DAC/packetizer path. Backpressures the FIR side when its buffer is full.

## Interface
- LANES, 6, samples per input block
- IN_W, 32, input sample width (signed)
- OUT_W, 16, output sample width (signed)
- SHIFT, 15, arithmetic right shift applied before saturation (≥1)
- DEPTH, 2, block buffer entries (power of two, ≥2)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  din holds a valid block
- in_ready  out  1  block buffer can accept
- din  in  LANES*IN_W  lane k at bits [k*IN_W +: IN_W]; lane 0 = oldest sample
- out_valid  out  1  dout valid
- out_ready  in  1  sink accepts dout
- dout  out  OUT_W  requantized sample
- dout_sat  out  1  this sample was clipped
- dout_last  out  1  this sample is lane LANES-1 of its block

## Operation
- Accept: in_valid & in_ready at a rising edge writes all LANES requantized lanes and their sat flags into buffer entry wr_ptr; wr_ptr++ (mod DEPTH), count++.
- Requant per lane: s = x + 2^(SHIFT-1) (rounding) or s = x (truncation), computed at IN_W+1 bits; y = s >>> SHIFT; if y > 2^(OUT_W-1)-1 → 2^(OUT_W-1)-1, sat=1; if y < -2^(OUT_W-1) → -2^(OUT_W-1), sat=1; else y, sat=0.
- in_ready = rst_n & (count < DEPTH); depends only on registered state and rst_n. No pass-through when full: a pop in the same cycle does not enable a push.
- Read side: out_valid = (count != 0). dout/dout_sat come from entry rd_ptr, lane index lane_idx. dout_last = (lane_idx == LANES-1).
- Pop: out_valid & out_ready advances lane_idx. At lane_idx == LANES-1: lane_idx ← 0, rd_ptr++ (mod DEPTH), count--.
- Simultaneous accept and final-lane pop: count unchanged, both pointers advance.
- out_ready low holds dout, dout_sat, dout_last and out_valid stable.
- State: count (0..DEPTH), wr_ptr, rd_ptr, lane_idx (0..LANES-1). Effective states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).

## Timing
- Reset: count, wr_ptr, rd_ptr, lane_idx ← 0. out_valid=0, dout_last=0 (lane_idx=0). dout and dout_sat are don't-care while out_valid=0. in_ready=0 while rst_n low.
- Reset mid-block discards all buffered and partially emitted data. The first out_valid after reset is lane 0 of the first block accepted after reset.
- Latency: block accepted at edge N; lane 0 is presented with out_valid=1 after edge N, so it is consumable at edge N+1.
- Throughput: one sample per cycle with out_ready=1. With DEPTH≥2 and continuous upstream, output is bubble-free. Sustained upstream rate is at most 1 block per LANES cycles.

## Configuration
- FIR_OUT_SER_ROUND_EN defined: round-half-up (add 2^(SHIFT-1) before the shift).
- FIR_OUT_SER_ROUND_EN undefined: truncation toward −∞ (no add). Saturation is identical in both builds.

## Structure
- Shared package fir_pkg: LANES, FIR_IN_W (16), FIR_ACC_W (32), OUT_W, default SHIFT. The FIR and this block both import it.
- Sub-module fir_requant: combinational, one instance per lane, IN_W → OUT_W + sat flag; contains the ROUND_EN conditional.
- Top contains the buffer, pointers and read mux.

## Test plan
- Rounding, SHIFT=15, lanes {32768, 16384, -16384, 0, 49152, -32768}: ROUND_EN gives {1, 1, 0, 0, 2, -1}; truncation gives {1, 0, -1, 0, 1, -1}. dout_last only on the sixth sample.
- Saturation, lanes {0x7FFFFFFF, 0x80000000, 32767·32768, 32768·32768, -32768·32768, -32769·32768}: dout {32767, -32768, 32767, 32767, -32768, -32768}; dout_sat {1, 1, 0, 1, 0, 1}.
- Backpressure: offer 3 blocks back-to-back with out_ready=0. Blocks 1–2 are accepted, then in_ready=0. Raise out_ready: 18 samples emerge in order, and in_ready rises in the cycle after the 6th pop.
- Streaming: in_valid held, out_ready=1, FIR sine+noise stimulus. No output gaps after the first sample; samples match the golden FIR model requantized.
- Random out_ready (50%): dout stable while stalled; no loss or duplication over 200 blocks.
- Reset asserted after 3 samples of a block: out_valid=0 the cycle after. After release, the first sample is lane 0 of a new block.
